// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a single-entry skid
// buffer behind the decode slot, and redirect handling with response kill.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          instruction,
  output logic [31:0]          pc_id,
  output logic                 instr_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pend_pc_reg;
  logic [31:0] skid_instr_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_id_reg;
  logic        req_reg;
  logic        kill_reg;
  logic        skid_valid_reg;
  logic        instr_valid_reg;

  logic        slot_free;
  logic [31:0] seq_pc;
  logic        redirect_pc_unused;

  // Targets are word aligned; the low bits of the computed target are dropped.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign slot_free = !instr_valid_reg || !stall;
  assign seq_pc    = pend_pc_reg + 32'd4;

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = pc_reg;
  assign instruction    = instr_reg;
  assign pc_id          = pc_id_reg;
  assign instr_valid    = instr_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      pend_pc_reg     <= 32'd0;
      skid_instr_reg  <= 32'd0;
      skid_pc_reg     <= 32'd0;
      instr_reg       <= 32'd0;
      pc_id_reg       <= 32'd0;
      req_reg         <= 1'b0;
      kill_reg        <= 1'b0;
      skid_valid_reg  <= 1'b0;
      instr_valid_reg <= 1'b0;
    end else begin
      // Decode consumes the current instruction; a load below overrides this.
      if (instr_valid_reg && !stall) begin
        instr_valid_reg <= 1'b0;
      end

      if (redirect) begin
        pc_reg          <= {redirect_pc[31:2], 2'b00};
        instr_valid_reg <= 1'b0;
        skid_valid_reg  <= 1'b0;
        case (state_reg)
          REQ: begin
            if (imem.imem_gnt) begin
              // Request already accepted: its response must be thrown away.
              state_reg <= WAIT;
              kill_reg  <= 1'b1;
              req_reg   <= 1'b0;
            end else begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
            end
          end
          WAIT: begin
            if (imem.imem_rvalid) begin
              state_reg <= REQ;
              kill_reg  <= 1'b0;
              req_reg   <= 1'b1;
            end else begin
              state_reg <= WAIT;
              kill_reg  <= 1'b1;
              req_reg   <= 1'b0;
            end
          end
          default: begin
            state_reg <= REQ;
            kill_reg  <= 1'b0;
            req_reg   <= 1'b1;
          end
        endcase
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
          end
          REQ: begin
            if (imem.imem_gnt) begin
              pend_pc_reg <= pc_reg;
              state_reg   <= WAIT;
              req_reg     <= 1'b0;
            end
          end
          WAIT: begin
            if (imem.imem_rvalid) begin
              if (kill_reg) begin
                kill_reg  <= 1'b0;
                state_reg <= REQ;
                req_reg   <= 1'b1;
              end else if (slot_free) begin
                instr_reg       <= imem.imem_rdata;
                pc_id_reg       <= pend_pc_reg;
                instr_valid_reg <= 1'b1;
                pc_reg          <= seq_pc;
                state_reg       <= REQ;
                req_reg         <= 1'b1;
              end else begin
                skid_instr_reg <= imem.imem_rdata;
                skid_pc_reg    <= pend_pc_reg;
                skid_valid_reg <= 1'b1;
                pc_reg         <= seq_pc;
                state_reg      <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall && skid_valid_reg) begin
              instr_reg       <= skid_instr_reg;
              pc_id_reg       <= skid_pc_reg;
              instr_valid_reg <= 1'b1;
              skid_valid_reg  <= 1'b0;
              state_reg       <= REQ;
              req_reg         <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory cycle
// by cycle and checks outputs 1 ns after each rising edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_id;
  logic        instr_valid;

  int checks;
  int errors;

  fetch_stage_if ibus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (ibus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .pc_id       (pc_id),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".imem_req"},    {31'd0, ibus.imem_req}, {31'd0, req});
    chk({tag, ".imem_addr"},   ibus.imem_addr, addr);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, vld});
    chk({tag, ".instruction"}, instruction, ins);
    chk({tag, ".pc_id"},       pc_id, pc);
    $display("step %s: req=%0b addr=%h valid=%0b instr=%h pc_id=%h",
             tag, ibus.imem_req, ibus.imem_addr, instr_valid, instruction, pc_id);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'd0;
    ibus.imem_gnt   = 1'b0;
    ibus.imem_rvalid = 1'b0;
    ibus.imem_rdata = 32'd0;

    // Reset state
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Release; first cycle is IDLE, request appears in the second
    rst_n         = 1'b1;
    ibus.imem_gnt = 1'b1;
    chk({"rel_idle", ".imem_req"}, {31'd0, ibus.imem_req}, 32'd0);
    tick();
    chk_out("first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Zero-wait fetches of 0x0 and 0x4
    tick();
    chk({"wait0", ".imem_req"}, {31'd0, ibus.imem_req}, 32'd0);
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'h0050_0093;
    tick();
    chk_out("resp0", 1'b1, 32'h4, 1'b1, 32'h0050_0093, 32'h0);
    ibus.imem_rvalid = 1'b0;
    tick();
    chk_out("consumed0", 1'b0, 32'h4, 1'b0, 32'h0050_0093, 32'h0);
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'h0010_0113;
    tick();
    chk_out("resp4", 1'b1, 32'h8, 1'b1, 32'h0010_0113, 32'h4);
    ibus.imem_rvalid = 1'b0;
    ibus.imem_gnt    = 1'b0;

    // Grant withheld for 3 edges: request held with stable address
    tick();
    chk_out("nogrant1", 1'b1, 32'h8, 1'b0, 32'h0010_0113, 32'h4);
    tick();
    chk_out("nogrant2", 1'b1, 32'h8, 1'b0, 32'h0010_0113, 32'h4);
    tick();
    chk_out("nogrant3", 1'b1, 32'h8, 1'b0, 32'h0010_0113, 32'h4);
    ibus.imem_gnt = 1'b1;
    tick();
    chk_out("granted8", 1'b0, 32'h8, 1'b0, 32'h0010_0113, 32'h4);
    ibus.imem_gnt = 1'b0;
    tick();
    chk_out("still_wait8", 1'b0, 32'h8, 1'b0, 32'h0010_0113, 32'h4);
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'h0000_0013;
    tick();
    chk_out("resp8", 1'b1, 32'hC, 1'b1, 32'h0000_0013, 32'h8);

    // Stall while the next response arrives: skid and hold
    ibus.imem_rvalid = 1'b0;
    stall            = 1'b1;
    ibus.imem_gnt    = 1'b1;
    tick();
    chk_out("stall_wait", 1'b0, 32'hC, 1'b1, 32'h0000_0013, 32'h8);
    ibus.imem_gnt    = 1'b0;
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'hFE00_0EE3;
    tick();
    ibus.imem_rvalid = 1'b0;
    chk_out("hold1", 1'b0, 32'h10, 1'b1, 32'h0000_0013, 32'h8);
    tick();
    chk_out("hold2", 1'b0, 32'h10, 1'b1, 32'h0000_0013, 32'h8);
    stall = 1'b0;
    tick();
    chk_out("skid_out", 1'b1, 32'h10, 1'b1, 32'hFE00_0EE3, 32'hC);

    // Redirect during WAIT kills the outstanding response
    ibus.imem_gnt = 1'b1;
    tick();
    chk_out("wait16", 1'b0, 32'h10, 1'b0, 32'hFE00_0EE3, 32'hC);
    ibus.imem_gnt = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = 32'h0000_0103;
    tick();
    redirect         = 1'b0;
    chk_out("redir_wait", 1'b0, 32'h100, 1'b0, 32'hFE00_0EE3, 32'hC);
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    ibus.imem_rvalid = 1'b0;
    chk_out("killed", 1'b1, 32'h100, 1'b0, 32'hFE00_0EE3, 32'hC);

    // Redirect in REQ to the top word, then fetch wraps to 0
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect      = 1'b0;
    chk_out("redir_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3, 32'hC);
    ibus.imem_gnt = 1'b1;
    tick();
    ibus.imem_gnt    = 1'b0;
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'h0000_0073;
    tick();
    ibus.imem_rvalid = 1'b0;
    chk_out("wrap", 1'b1, 32'h0, 1'b1, 32'h0000_0073, 32'hFFFF_FFFC);

    // Reset asserted mid-WAIT: outputs clear immediately, late response ignored
    stall         = 1'b1;
    ibus.imem_gnt = 1'b1;
    tick();
    ibus.imem_gnt = 1'b0;
    chk_out("pre_reset", 1'b0, 32'h0, 1'b1, 32'h0000_0073, 32'hFFFF_FFFC);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    tick();
    rst_n            = 1'b1;
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'h1111_1111;
    tick();
    ibus.imem_rvalid = 1'b0;
    chk_out("late_resp", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Redirect coinciding with a live response drops it
    ibus.imem_gnt = 1'b1;
    tick();
    ibus.imem_gnt    = 1'b0;
    ibus.imem_rvalid = 1'b1;
    ibus.imem_rdata  = 32'h2222_2222;
    redirect         = 1'b1;
    redirect_pc      = 32'h0000_0040;
    tick();
    ibus.imem_rvalid = 1'b0;
    redirect         = 1'b0;
    chk_out("redir_rvalid", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
